ram_arbiter: RTL and testbench

- Shares one single-port 8-bit RAM between two requesters: A (CPU) and B (loader/DMA).
- Sits directly in front of the RAM. It drives the RAM address, write enable and write data, and returns read data to whichever requester issued the access.
- Round-robin arbitration. Optional locked bursts are limited by a maximum burst counter so neither side starves.

---
 rtl/ram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 8-bit RAM.
// Requester A (CPU) and B (loader/DMA) may lock ownership for a bounded burst;
// read data returns one cycle after the grant, tagged with the issuing side.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | no owner; ties go to the side that did not win last time
//  ST_OWN_A | A holds a lock; A wins whenever it requests
//  ST_OWN_B | B holds a lock; B wins whenever it requests
module ram_arbiter #(
  parameter int ADDR_BITS = 13,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_lock,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [7:0]           a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [7:0]           a_rdata,
  input  logic                 b_req,
  input  logic                 b_lock,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [7:0]           b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [7:0]           b_rdata,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_di,
  input  logic [7:0]           ram_do
);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN_A, ST_OWN_B} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_A, RD_B} rd_owner_t;

  // Burst counter value at which the owner is forced to hand over.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  // With a one-grant burst a lock can never be held, so it is ignored.
  localparam bit LOCK_EN = (MAX_BURST > 1);

  state_t                 state_q, state_d;
  logic [7:0]             burst_cnt_q, burst_cnt_d;
  logic                   last_b_q, last_b_d;     // 1: last grant went to B
  rd_owner_t              rd_owner_q, rd_owner_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [7:0]             di_q, di_d;
  logic                   gnt_a, gnt_b;

  // Grant decision: a requesting owner wins, otherwise round-robin on ties.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      if (state_q == ST_OWN_A && a_req) begin
        gnt_a = 1'b1;
      end else if (state_q == ST_OWN_B && b_req) begin
        gnt_b = 1'b1;
      end else if (a_req && b_req) begin
        if (last_b_q) gnt_a = 1'b1;
        else          gnt_b = 1'b1;
      end else if (a_req) begin
        gnt_a = 1'b1;
      end else if (b_req) begin
        gnt_b = 1'b1;
      end
    end
  end

  // Next-state: ownership/burst tracking, last winner, read tag, held address.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_b_d    = last_b_q;
    rd_owner_d  = RD_NONE;
    addr_d      = addr_q;
    di_d        = di_q;

    if (gnt_a) begin
      last_b_d = 1'b0;
      addr_d   = a_addr;
      di_d     = a_wdata;
      if (!a_we) rd_owner_d = RD_A;
    end else if (gnt_b) begin
      last_b_d = 1'b1;
      addr_d   = b_addr;
      di_d     = b_wdata;
      if (!b_we) rd_owner_d = RD_B;
    end

    case (state_q)
      ST_IDLE: begin
        if (LOCK_EN && gnt_a && a_lock) begin
          state_d     = ST_OWN_A;
          burst_cnt_d = 8'd1;
        end else if (LOCK_EN && gnt_b && b_lock) begin
          state_d     = ST_OWN_B;
          burst_cnt_d = 8'd1;
        end
      end
      ST_OWN_A: begin
        // Any grant without lock, burst exhaustion, or an idle owner releases.
        if (gnt_a && a_lock && burst_cnt_q < BURST_LAST) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
          state_d     = ST_IDLE;
          burst_cnt_d = 8'd0;
        end
      end
      ST_OWN_B: begin
        if (gnt_b && b_lock && burst_cnt_q < BURST_LAST) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
          state_d     = ST_IDLE;
          burst_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= 8'd0;
      last_b_q    <= 1'b1;
      rd_owner_q  <= RD_NONE;
      addr_q      <= '0;
      di_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_b_q    <= last_b_d;
      rd_owner_q  <= rd_owner_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
    end
  end

  // RAM drive from the granted side; address and data hold when idle.
  always_comb begin
    a_gnt    = gnt_a;
    b_gnt    = gnt_b;
    ram_we   = (gnt_a & a_we) | (gnt_b & b_we);
    ram_addr = addr_q;
    ram_di   = di_q;
    if (rst) begin
      ram_addr = '0;
      ram_di   = 8'd0;
    end else if (gnt_a) begin
      ram_addr = a_addr;
      ram_di   = a_wdata;
    end else if (gnt_b) begin
      ram_addr = b_addr;
      ram_di   = b_wdata;
    end
  end

  // Read return: tag from the previous cycle; a tag left over from the cycle
  // before reset must not surface while reset is asserted.
  always_comb begin
    a_rvalid = !rst && (rd_owner_q == RD_A);
    b_rvalid = !rst && (rd_owner_q == RD_B);
    a_rdata  = ram_do;
    b_rdata  = ram_do;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed vector table, hand-written lock/reset
// sequences and a randomized run checked against a transaction-level model.
module tb_ram_arbiter;

  localparam int AB = 13;
  localparam int MB = 8;

  logic          clk;
  logic          rst;
  logic          a_req, a_lock, a_we, b_req, b_lock, b_we;
  logic [AB-1:0] a_addr, b_addr, ram_addr;
  logic [7:0]    a_wdata, b_wdata, a_rdata, b_rdata, ram_di, ram_do;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;

  int n_checks = 0;
  int n_fail   = 0;

  ram_arbiter #(.ADDR_BITS(AB), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with registered address.
  logic [7:0]    mem [0:(1<<AB)-1];
  logic [AB-1:0] addr_r;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_di;
    addr_r <= ram_addr;
  end
  assign ram_do = mem[addr_r];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ar, input logic al, input logic aw,
                       input logic [AB-1:0] aa, input logic [7:0] ad,
                       input logic br, input logic bl, input logic bw,
                       input logic [AB-1:0] ba, input logic [7:0] bd);
    rst = r;
    a_req = ar; a_lock = al; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_lock = bl; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic          ar, al, aw;
    logic [AB-1:0] aa;
    logic [7:0]    ad;
    logic          br, bl, bw;
    logic [AB-1:0] ba;
    logic [7:0]    bd;
    logic          e_ag, e_bg, e_we, e_arv, e_brv;
    logic [7:0]    e_rd;
  } vec_t;

  function automatic vec_t v(logic r, logic ar, logic al, logic aw, logic [AB-1:0] aa,
                             logic [7:0] ad, logic br, logic bl, logic bw,
                             logic [AB-1:0] ba, logic [7:0] bd, logic eag, logic ebg,
                             logic ewe, logic earv, logic ebrv, logic [7:0] erd);
    vec_t t;
    t.rst = r; t.ar = ar; t.al = al; t.aw = aw; t.aa = aa; t.ad = ad;
    t.br = br; t.bl = bl; t.bw = bw; t.ba = ba; t.bd = bd;
    t.e_ag = eag; t.e_bg = ebg; t.e_we = ewe; t.e_arv = earv; t.e_brv = ebrv; t.e_rd = erd;
    return t;
  endfunction

  // Checks grants only, at the current negedge, then advances.
  task automatic cyc_gnt(input string nm, input logic eag, input logic ebg);
    @(negedge clk);
    chk({nm, " a_gnt"}, 32'(a_gnt), 32'(eag));
    chk({nm, " b_gnt"}, 32'(b_gnt), 32'(ebg));
    next_cycle();
  endtask

  vec_t vecs [16];

  // Reference model state (transaction level).
  int            owner;     // 0 none, 1 A, 2 B
  int            run;       // grants so far in the current locked run
  int            last;      // 1 A, 2 B
  int            pend;      // side whose read returns next cycle
  logic          pend_known;
  logic [7:0]    pend_data;
  logic [7:0]    shadow  [0:(1<<AB)-1];
  bit            written [0:(1<<AB)-1];

  // Random requesters
  logic          pa_v, pa_l, pa_w, pb_v, pb_l, pb_w;
  logic [AB-1:0] pa_a, pb_a;
  logic [7:0]    pa_d, pb_d;

  function automatic logic [AB-1:0] rnd_addr();
    logic [AB-1:0] base;
    base = ($urandom_range(0, 1) == 1) ? AB'(13'h1FF0) : AB'(0);
    return base + AB'($urandom_range(0, 15));
  endfunction

  initial begin
    drive(1, 1, 0, 0, 13'h10, 0, 1, 0, 0, 13'h10, 0);
    next_cycle();

    // ---------------- directed vector table ----------------
    vecs[0]  = v(1, 1,0,0,13'h0010,8'h00, 1,0,0,13'h0010,8'h00, 0,0,0,0,0,8'h00);
    vecs[1]  = v(1, 1,0,0,13'h0010,8'h00, 1,0,0,13'h0010,8'h00, 0,0,0,0,0,8'h00);
    vecs[2]  = v(1, 1,0,0,13'h0010,8'h00, 1,0,0,13'h0010,8'h00, 0,0,0,0,0,8'h00);
    vecs[3]  = v(0, 1,0,1,13'h0010,8'h5A, 1,0,0,13'h0010,8'h00, 1,0,1,0,0,8'h00);
    vecs[4]  = v(0, 0,0,0,13'h0000,8'h00, 1,0,0,13'h0010,8'h00, 0,1,0,0,0,8'h00);
    vecs[5]  = v(0, 0,0,0,13'h0000,8'h00, 0,0,0,13'h0000,8'h00, 0,0,0,0,1,8'h5A);
    vecs[6]  = v(0, 1,0,1,13'h0001,8'h11, 0,0,0,13'h0000,8'h00, 1,0,1,0,0,8'h00);
    vecs[7]  = v(0, 1,0,1,13'h0002,8'h22, 0,0,0,13'h0000,8'h00, 1,0,1,0,0,8'h00);
    vecs[8]  = v(0, 0,0,0,13'h0000,8'h00, 1,0,1,13'h1000,8'h33, 0,1,1,0,0,8'h00);
    vecs[9]  = v(0, 0,0,0,13'h0000,8'h00, 1,0,1,13'h1001,8'h44, 0,1,1,0,0,8'h00);
    vecs[10] = v(0, 1,0,0,13'h0001,8'h00, 1,0,0,13'h1000,8'h00, 1,0,0,0,0,8'h00);
    vecs[11] = v(0, 1,0,0,13'h0002,8'h00, 1,0,0,13'h1000,8'h00, 0,1,0,1,0,8'h11);
    vecs[12] = v(0, 1,0,0,13'h0002,8'h00, 1,0,0,13'h1001,8'h00, 1,0,0,0,1,8'h33);
    vecs[13] = v(0, 0,0,0,13'h0000,8'h00, 1,0,0,13'h1001,8'h00, 0,1,0,1,0,8'h22);
    vecs[14] = v(0, 0,0,0,13'h0000,8'h00, 0,0,0,13'h0000,8'h00, 0,0,0,0,1,8'h44);
    vecs[15] = v(0, 0,0,0,13'h0000,8'h00, 0,0,0,13'h0000,8'h00, 0,0,0,0,0,8'h00);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].ar, vecs[i].al, vecs[i].aw, vecs[i].aa, vecs[i].ad,
            vecs[i].br, vecs[i].bl, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      @(negedge clk);
      chk($sformatf("vec%0d a_gnt", i),    32'(a_gnt),    32'(vecs[i].e_ag));
      chk($sformatf("vec%0d b_gnt", i),    32'(b_gnt),    32'(vecs[i].e_bg));
      chk($sformatf("vec%0d ram_we", i),   32'(ram_we),   32'(vecs[i].e_we));
      chk($sformatf("vec%0d a_rvalid", i), 32'(a_rvalid), 32'(vecs[i].e_arv));
      chk($sformatf("vec%0d b_rvalid", i), 32'(b_rvalid), 32'(vecs[i].e_brv));
      if (vecs[i].e_arv) chk($sformatf("vec%0d a_rdata", i), 32'(a_rdata), 32'(vecs[i].e_rd));
      if (vecs[i].e_brv) chk($sformatf("vec%0d b_rdata", i), 32'(b_rdata), 32'(vecs[i].e_rd));
      if (vecs[i].rst)   chk($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(0));
      next_cycle();
    end

    // ---------------- locked burst: 8 grants to A, then B, then A ----------------
    drive(0, 1, 1, 0, 13'h0001, 0, 1, 0, 0, 13'h1000, 0);
    for (int i = 0; i < 10; i++)
      cyc_gnt($sformatf("burst%0d", i), (i < MB) || (i == MB + 1), i == MB);

    // ---------------- lock release: owner A drops req for one cycle ----------------
    drive(0, 0, 1, 0, 13'h0001, 0, 1, 0, 0, 13'h1000, 0);
    cyc_gnt("release", 0, 1);
    drive(0, 1, 0, 0, 13'h0001, 0, 1, 0, 0, 13'h1000, 0);
    cyc_gnt("after_release", 1, 0);
    drive(0, 0, 0, 0, 13'h0001, 0, 0, 0, 0, 13'h1000, 0);
    next_cycle();

    // ---------------- reset mid-burst ----------------
    drive(0, 1, 1, 0, 13'h0002, 0, 0, 0, 0, 13'h1000, 0);
    cyc_gnt("rstburst_n", 1, 0);
    drive(1, 1, 1, 0, 13'h0002, 0, 1, 0, 0, 13'h1000, 0);
    @(negedge clk);
    chk("rstburst a_rvalid", 32'(a_rvalid), 32'(0));
    chk("rstburst a_gnt", 32'(a_gnt), 32'(0));
    chk("rstburst ram_we", 32'(ram_we), 32'(0));
    next_cycle();
    drive(0, 1, 0, 0, 13'h0002, 0, 1, 0, 0, 13'h1000, 0);
    @(negedge clk);
    chk("post_rst a_rvalid", 32'(a_rvalid), 32'(0));
    next_cycle();
    // cycle above granted A (first tie after reset); the tie after it goes to B
    drive(0, 1, 0, 0, 13'h0002, 0, 1, 0, 0, 13'h1000, 0);
    cyc_gnt("post_rst tie2", 0, 1);

    // ---------------- randomized run against the model ----------------
    pa_v = 0; pb_v = 0;
    pa_l = 0; pa_w = 0; pa_a = 0; pa_d = 0;
    pb_l = 0; pb_w = 0; pb_a = 0; pb_d = 0;
    owner = 0; run = 0; last = 2; pend = 0; pend_known = 0; pend_data = 0;
    for (int it = 0; it < 3000; it++) begin
      logic r;
      int   g;
      logic g_lock, g_we;
      logic [AB-1:0] g_addr;
      logic [7:0]    g_data;
      r = (it < 2) || ($urandom_range(0, 59) == 0);
      if (!pa_v && $urandom_range(0, 9) < 6) begin
        pa_v = 1; pa_l = 1'($urandom_range(0, 1)); pa_w = ($urandom_range(0, 9) < 4);
        pa_a = rnd_addr(); pa_d = 8'($urandom);
      end
      if (!pb_v && $urandom_range(0, 9) < 6) begin
        pb_v = 1; pb_l = 1'($urandom_range(0, 1)); pb_w = ($urandom_range(0, 9) < 4);
        pb_a = rnd_addr(); pb_d = 8'($urandom);
      end
      drive(r, pa_v, pa_l, pa_w, pa_a, pa_d, pb_v, pb_l, pb_w, pb_a, pb_d);

      // Expected winner this cycle.
      g = 0;
      if (!r) begin
        if (owner == 1 && pa_v)       g = 1;
        else if (owner == 2 && pb_v)  g = 2;
        else if (pa_v && pb_v)        g = (last == 1) ? 2 : 1;
        else if (pa_v)                g = 1;
        else if (pb_v)                g = 2;
      end
      g_lock = (g == 1) ? pa_l : pb_l;
      g_we   = (g == 1) ? pa_w : pb_w;
      g_addr = (g == 1) ? pa_a : pb_a;
      g_data = (g == 1) ? pa_d : pb_d;

      @(negedge clk);
      chk("rnd a_gnt", 32'(a_gnt), 32'(g == 1));
      chk("rnd b_gnt", 32'(b_gnt), 32'(g == 2));
      chk("rnd ram_we", 32'(ram_we), 32'((g != 0) && g_we));
      chk("rnd a_rvalid", 32'(a_rvalid), 32'(!r && pend == 1));
      chk("rnd b_rvalid", 32'(b_rvalid), 32'(!r && pend == 2));
      if (g != 0) chk("rnd ram_addr", 32'(ram_addr), 32'(g_addr));
      if (g != 0 && g_we) chk("rnd ram_di", 32'(ram_di), 32'(g_data));
      if (!r && pend == 1 && pend_known) chk("rnd a_rdata", 32'(a_rdata), 32'(pend_data));
      if (!r && pend == 2 && pend_known) chk("rnd b_rdata", 32'(b_rdata), 32'(pend_data));

      if (r) begin
        owner = 0; run = 0; last = 2; pend = 0;
      end else begin
        pend = 0;
        if (g != 0) begin
          last = g;
          if (!g_we) begin
            pend = g; pend_known = written[g_addr]; pend_data = shadow[g_addr];
          end else begin
            shadow[g_addr] = g_data; written[g_addr] = 1;
          end
        end
        if (owner != 0) begin
          if (g == owner && g_lock) begin
            run++;
            if (run >= MB) owner = 0;
          end else begin
            owner = 0;
          end
        end else if (g != 0 && g_lock) begin
          owner = g; run = 1;
          if (run >= MB) owner = 0;
        end
        if (g == 1) pa_v = 0;
        if (g == 2) pb_v = 0;
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
